deem_filter_stream: RTL



---
 rtl/deem_pkg.sv | 17 +
 rtl/deem_narrow_sat.sv | 18 +
 rtl/deem_filter_stream.sv | 95 +++++++++
 3 files changed

// File: rtl/deem_pkg.sv
// Shared widths, saturation limits and output-stage states for the de-emphasis path.
package deem_pkg;

    localparam int IN_W  = 11;
    localparam int ACC_W = 17;

    localparam logic signed [IN_W-1:0]  SAT_MAX_IN  = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0]  SAT_MIN_IN  = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX_ACC = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN_ACC = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/deem_narrow_sat.sv
// Combinational ACC_W -> IN_W saturating narrower; clip flags a clamped value.
module deem_narrow_sat
    import deem_pkg::*;
(
    input  logic signed [ACC_W-1:0] wide,
    output logic signed [IN_W-1:0]  narrow,
    output logic                    clip
);

    logic [ACC_W-IN_W:0] upper;

    // Value fits when every bit above the narrow sign bit matches it.
    assign upper  = wide[ACC_W-1:IN_W-1];
    assign clip   = !((&upper) || (~|upper));
    assign narrow = !clip ? wide[IN_W-1:0] :
                    (wide[ACC_W-1] ? SAT_MIN_IN : SAT_MAX_IN);

endmodule

// File: rtl/deem_filter_stream.sv
// De-emphasis IIR y[n] = x[n] + y[n-1] - (y[n-1] >>> SHIFT) with valid/ready on both sides.
// Optional saturation event counter enabled by DEEM_SAT_CNT_EN.
//
// state | meaning
// EMPTY | no output held, out_valid = 0
// FULL  | out_data held, out_valid = 1
module deem_filter_stream
    import deem_pkg::*;
#(
    parameter int unsigned SHIFT = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic signed [IN_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sat
`ifdef DEEM_SAT_CNT_EN
    ,
    output logic [15:0]            sat_count
`endif
);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] acc_next;
    logic                    acc_clip;
    logic signed [IN_W-1:0]  out_next;
    logic                    out_clip;
    logic                    sat_next;
    logic                    accept;

    assign in_ready = !clear && (state == EMPTY || out_ready);
    assign accept   = in_valid && in_ready;

    // One guard bit keeps the sum exact before clamping to the accumulator range.
    assign acc_shr  = acc >>> SHIFT;
    assign sum      = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data}
                    + {acc[ACC_W-1], acc}
                    - {acc_shr[ACC_W-1], acc_shr};
    assign acc_clip = sum[ACC_W] != sum[ACC_W-1];
    assign acc_next = !acc_clip ? sum[ACC_W-1:0] :
                      (sum[ACC_W] ? SAT_MIN_ACC : SAT_MAX_ACC);
    assign sat_next = acc_clip || out_clip;

    deem_narrow_sat u_out_sat (
        .wide   (acc_next),
        .narrow (out_next),
        .clip   (out_clip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            state     <= EMPTY;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else if (accept) begin
            state     <= FULL;
            acc       <= acc_next;
            out_data  <= out_next;
            out_valid <= 1'b1;
            out_sat   <= sat_next;
        end else if (state == FULL && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end
    end

`ifdef DEEM_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clear) begin
            sat_count <= '0;
        end else if (accept && sat_next && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule
